// File: rtl/tweak_prog_loader.sv
// Framed byte-stream loader for the 16-entry instruction store; holds the CPU
// in reset until a frame verifies. Optional opcode screen: TWEAK_LOADER_FMTCHK_EN.
// Ports: CLK, NRES (async low); start; byte_valid/byte_data/byte_ready;
// wr_ena/wr_addr/wr_data; cpu_hold, done, err, word_count.
module tweak_prog_loader #(
  parameter int NUMWORDS = 16,
  parameter int WORDSIZE = 32,
  parameter int ADDRBITS = 4
) (
  input  logic                CLK,
  input  logic                NRES,
  input  logic                start,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                wr_ena,
  output logic [ADDRBITS-1:0] wr_addr,
  output logic [WORDSIZE-1:0] wr_data,
  output logic                cpu_hold,
  output logic                done,
  output logic                err,
  output logic [ADDRBITS:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, CSUM, DONE, ERR
  } state_t;

  localparam logic [ADDRBITS:0] ONE = 1;
  localparam logic [7:0] MAXN = 8'(NUMWORDS);

  state_t state_q, state_d;

  logic [1:0]          bcnt;
  logic [23:0]         asm_q;
  logic [7:0]          csum;
  logic [ADDRBITS:0]   n_q;
  logic                xfer;
  logic                busy;
  logic                hdr_bad;
  logic                last_word;
  logic                fmt_ok;

  assign busy       = (state_q == HDR) | (state_q == DATA)
                    | (state_q == CSUM);
  assign byte_ready = busy & ~start;
  assign xfer       = byte_valid & byte_ready;
  assign hdr_bad    = (byte_data == 8'd0) | (byte_data > MAXN);
  assign last_word  = (word_count + ONE) == n_q;

  // byte 0 of the word sits in asm_q[23:16] when byte 3 arrives
`ifdef TWEAK_LOADER_FMTCHK_EN
  assign fmt_ok = (asm_q[23:21] == 3'b000);
`else
  assign fmt_ok = 1'b1;
`endif

  assign cpu_hold = (state_q != DONE);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);
  assign wr_addr  = word_count[ADDRBITS-1:0];

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = HDR;
    end else if (xfer) begin
      unique case (1'b1)
        (state_q == HDR):
          state_d = hdr_bad ? ERR : DATA;
        (state_q == DATA):
          if (bcnt == 2'd3) begin
            if (!fmt_ok)        state_d = ERR;
            else if (last_word) state_d = CSUM;
          end
        (state_q == CSUM):
          state_d = (byte_data == csum) ? DONE : ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      bcnt       <= '0;
      asm_q      <= '0;
      csum       <= '0;
      n_q        <= '0;
      wr_ena     <= 1'b0;
      wr_data    <= '0;
      word_count <= '0;
    end else begin
      wr_ena <= 1'b0;
      // count advances at the end of the write cycle
      if (wr_ena) word_count <= word_count + ONE;
      if (start) begin
        bcnt       <= '0;
        csum       <= '0;
        word_count <= '0;
      end else if (xfer) begin
        unique case (1'b1)
          (state_q == HDR): begin
            n_q  <= byte_data[ADDRBITS:0];
            csum <= byte_data;
          end
          (state_q == DATA): begin
            csum  <= csum ^ byte_data;
            bcnt  <= bcnt + 2'd1;
            asm_q <= {asm_q[15:0], byte_data};
            if (bcnt == 2'd3) begin
              wr_data <= {asm_q, byte_data};
              wr_ena  <= fmt_ok;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tweak_prog_loader.sv
// Directed bench for tweak_prog_loader with a write scoreboard.
// Ports: drives all DUT inputs, checks all outputs.
module tb_tweak_prog_loader;

  logic        CLK;
  logic        NRES;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_ena;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [4:0]  word_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] cs;
  logic [35:0] sb[$];

  tweak_prog_loader dut (
    .CLK(CLK), .NRES(NRES), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_ena(wr_ena),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err),
    .word_count(word_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [35:0] e;
    @(posedge CLK);
    #1;
    if (wr_ena) begin
      if (sb.size() == 0) begin
        chk("wr_unexpected", {63'd0, wr_ena}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wr", {28'd0, wr_addr, wr_data}, {28'd0, e});
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    cs = cs ^ b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input logic [3:0] a,
                           input bit wr);
    if (wr) sb.push_back({a, w});
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    cs = 8'h00;
  endtask

  initial begin
    NRES = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    cs = 8'h00;
    #12;
    chk("rst_ready", {63'd0, byte_ready}, 64'd0);
    chk("rst_wr_ena", {63'd0, wr_ena}, 64'd0);
    chk("rst_wr_addr", {60'd0, wr_addr}, 64'd0);
    chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
    chk("rst_hold", {63'd0, cpu_hold}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_wc", {59'd0, word_count}, 64'd0);
    @(negedge CLK);
    NRES = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h01;
    tick();
    chk("idle_refuse", {63'd0, byte_ready}, 64'd0);
    byte_valid = 1'b0;

    // N=1 frame, minimum latency
    pulse_start();
    chk("t1_hdr_ready", {63'd0, byte_ready}, 64'd1);
    send(8'h01);
    send_word(32'h00888888, 4'd0, 1'b1);
    chk("t1_csum_val", {56'd0, cs}, 64'h89);
    send(cs);
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_hold", {63'd0, cpu_hold}, 64'd0);
    chk("t1_wc", {59'd0, word_count}, 64'd1);
    chk("t1_ready", {63'd0, byte_ready}, 64'd0);

    // N=2 frame with a mid-word stall
    pulse_start();
    send(8'h02);
    sb.push_back({4'd0, 32'h00444444});
    send(8'h00); send(8'h44);
    repeat (3) tick();
    chk("t2_stall_wc", {59'd0, word_count}, 64'd0);
    send(8'h44); send(8'h44);
    send_word(32'h11012000, 4'd1, 1'b1);
    send(cs);
    chk("t2_done", {63'd0, done}, 64'd1);
    chk("t2_err", {63'd0, err}, 64'd0);
    chk("t2_wc", {59'd0, word_count}, 64'd2);

    // same frame, corrupted checksum
    pulse_start();
    chk("t3_clr_done", {63'd0, done}, 64'd0);
    send(8'h02);
    send_word(32'h00444444, 4'd0, 1'b1);
    send_word(32'h11012000, 4'd1, 1'b1);
    send(cs ^ 8'h01);
    chk("t3_err", {63'd0, err}, 64'd1);
    chk("t3_done", {63'd0, done}, 64'd0);
    chk("t3_hold", {63'd0, cpu_hold}, 64'd1);
    tick();
    chk("t3_err_sticky", {63'd0, err}, 64'd1);

    // illegal headers
    pulse_start();
    chk("t4_clr_err", {63'd0, err}, 64'd0);
    send(8'h00);
    chk("t4_hdr0_err", {63'd0, err}, 64'd1);
    pulse_start();
    send(8'h11);
    chk("t4_hdr17_err", {63'd0, err}, 64'd1);
    chk("t4_hold", {63'd0, cpu_hold}, 64'd1);

    // restart mid-frame
    pulse_start();
    send(8'h02);
    send_word(32'h00444444, 4'd0, 1'b1);
    send(8'h11); send(8'h01);
    start = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h01;
    #1;
    chk("t5_refuse", {63'd0, byte_ready}, 64'd0);
    tick();
    start = 1'b0;
    byte_valid = 1'b0;
    #1;
    cs = 8'h00;
    chk("t5_wc", {59'd0, word_count}, 64'd0);
    chk("t5_ready", {63'd0, byte_ready}, 64'd1);
    send(8'h01);
    send_word(32'h01020304, 4'd0, 1'b1);
    send(cs);
    chk("t5_done", {63'd0, done}, 64'd1);
    chk("t5_wc1", {59'd0, word_count}, 64'd1);

    // encoding screen
    pulse_start();
    send(8'h01);
`ifdef TWEAK_LOADER_FMTCHK_EN
    send_word(32'h27000000, 4'd0, 1'b0);
    chk("t6_err", {63'd0, err}, 64'd1);
    tick();
    chk("t6_wc", {59'd0, word_count}, 64'd0);
`else
    send_word(32'h27000000, 4'd0, 1'b1);
    send(cs);
    chk("t6_done", {63'd0, done}, 64'd1);
`endif

    // reset during a write cycle
    pulse_start();
    send(8'h01);
    send_word(32'h10000001, 4'd0, 1'b1);
    NRES = 1'b0;
    #1;
    chk("t7_wr_ena", {63'd0, wr_ena}, 64'd0);
    chk("t7_hold", {63'd0, cpu_hold}, 64'd1);
    chk("t7_wc", {59'd0, word_count}, 64'd0);
    chk("t7_ready", {63'd0, byte_ready}, 64'd0);
    chk("t7_data", {32'd0, wr_data}, 64'd0);
    @(negedge CLK);
    NRES = 1'b1;
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tweak_prog_loader.md
# tweak_prog_loader

Writer side of the instruction memory: accepts a framed byte stream (word count, big-endian 32-bit instruction words, XOR checksum), assembles the words and writes them into the 16-entry instruction store that the CPU fetch path reads. It holds the CPU in reset until a frame has loaded and verified cleanly. It sits between the host byte link and the instruction-memory write port. The CPU's `RESET` input is driven from `cpu_hold`.

## Interface
- `NUMWORDS`, 16, instruction store depth; the maximum word count in a frame.
- `WORDSIZE`, 32, instruction width in bits; fixed at 4 bytes.
- `ADDRBITS`, 4, instruction store address width.
- `CLK`  in  1  single clock; all state changes on posedge.
- `NRES`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins or restarts a frame.
- `byte_valid`  in  1  host presents `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle; a transfer happens when `byte_valid & byte_ready` at posedge.
- `wr_ena`  out  1  one-cycle instruction store write strobe.
- `wr_addr`  out  ADDRBITS  write address.
- `wr_data`  out  WORDSIZE  assembled instruction word.
- `cpu_hold`  out  1  active-high CPU reset request.
- `done`  out  1  frame loaded and checksum matched; sticky until `start`.
- `err`  out  1  frame rejected; sticky until `start`.
- `word_count`  out  ADDRBITS+1  words written in the current frame.

## Operation
- Frame format:
  - header byte N, with 1 ≤ N ≤ NUMWORDS;
  - 4·N data bytes, each word sent MSB first;
  - one checksum byte equal to the XOR of the header and all data bytes.
- FSM states: IDLE, HDR, DATA, CSUM, DONE, ERR.
- IDLE:
  - `start` → HDR.
  - Bytes are refused.
- HDR:
  - On the accepted byte, N==0 or N>NUMWORDS → ERR.
  - Otherwise latch N, seed the checksum with the byte, and go → DATA.
- DATA:
  - A 2-bit byte counter shifts bytes into a 32-bit assembly register: byte 0 goes to [31:24], byte 3 to [7:0].
  - Every byte is XORed into the running checksum.
  - After the 4th byte, the word is written at `wr_addr` = `word_count`, then `word_count` increments.
  - When `word_count` reaches N → CSUM.
- CSUM:
  - Accepted byte == running checksum → DONE.
  - Otherwise → ERR.
- DONE:
  - `done`=1 and `cpu_hold`=0.
  - Bytes are refused.
- ERR:
  - `err`=1 and `cpu_hold`=1.
  - Bytes are refused.
  - Words already written stay in memory but are not trusted.
- `byte_ready` = (state ∈ {HDR, DATA, CSUM}) & ~`start`.
- `start` in any state, including mid-frame, restarts:
  - clears the byte counter, `word_count`, checksum, `done` and `err`;
  - next state is HDR;
  - a byte presented in the same cycle as `start` is not consumed.
- `cpu_hold` = 1 in every state except DONE.
- Addresses never wrap, because N ≤ NUMWORDS bounds `wr_addr` to 0..N-1.

## Timing
- Reset values:
  - state IDLE, `byte_ready` 0, `wr_ena` 0, `wr_addr` 0, `wr_data` 0;
  - `cpu_hold` 1, `done` 0, `err` 0, `word_count` 0.
- Asserting `NRES` mid-frame aborts immediately to those values, with no partial write. A `wr_ena` already high drops asynchronously.
- `start` sampled at edge t: state is HDR and `byte_ready`=1 in cycle t+1.
- 4th byte of a word accepted at edge k:
  - `wr_ena`=1 with stable `wr_addr`/`wr_data` for exactly cycle k+1;
  - `word_count` updates at edge k+1.
- The next byte may be accepted at edge k+1. There are no stall cycles, and throughput is one byte per cycle.
- Checksum byte accepted at edge c: `done`/`err` are set and `cpu_hold` changes in cycle c+1.
- Minimum frame duration from `start` to `done` is 4·N+3 cycles.
- `byte_valid` low inserts idle cycles and does not change state.

## Configuration
- `TWEAK_LOADER_FMTCHK_EN` defined:
  - every assembled word's encoding field [31:28] must be 4'h0 (load immediate) or 4'h1 (three-operand ALU);
  - any other value suppresses that word's `wr_ena` and sends the FSM → ERR in the same cycle the write would have occurred.
- Not defined: every assembled word is written unchecked.

## Test plan
- Reset, then frame 01 00 88 88 88 89 → one write: addr 0, data 32'h00888888. `done`=1 and `cpu_hold`=0 at cycle 7 after `start`; `word_count`=1.
- Frame with N=2 (words 32'h00444444, 32'h11012000), checksum correct, `byte_valid` deasserted for 3 cycles mid-word → writes at addr 0 and 1 with correct data; `done`=1.
- Same frame with checksum byte XOR 8'h01 → both words written; `err`=1, `done`=0, `cpu_hold` stays 1.
- Header 8'h00 → `err` next cycle; header 8'h11 → `err` next cycle. No `wr_ena` in either case.
- `start` pulsed after 6 data bytes of an N=2 frame, with `byte_valid` high on that cycle → that byte is refused; `word_count`=0; a fresh N=1 frame then completes with `done`=1.
- With `TWEAK_LOADER_FMTCHK_EN` defined, word 32'h27000000 → no `wr_ena`, `err`=1 at the would-be write cycle. With the macro undefined, the same word is written at addr 0.
